// File: rtl/aes_serial_ctrl.sv
// aes_serial_ctrl: serial (CS/MOSI/MISO) front end that collects {cmd, data, key}, launches a cipher core and returns the result.
// Latency: core_start one cycle after the last key bit; MISO marker one cycle after core_done, then DATA_W result bits MSB first.
// Backpressure: none on the serial link; CS high mid-transaction aborts back to IDLE, a silent core times out after TIMEOUT_CYC cycles.
//
// Ports:
//   clk, reset         single clock, synchronous active-low reset
//   CS, MOSI, MISO     serial link (CS active low, MOSI sampled on rising clk, MISO released to Z when idle)
//   core_*             cipher core handshake: start pulse, mode, block, key in; done pulse, result back
//   busy, err          status: busy outside IDLE/DRAIN; err = sticky {cmd, timeout, abort}, cleared at frame start
module aes_serial_ctrl #(
    parameter int DATA_W      = 128,
    parameter int KEY_W       = 128,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              core_start,
    output logic              core_decrypt,
    output logic [DATA_W-1:0] core_data,
    output logic [KEY_W-1:0]  core_key,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic              busy,
    output logic [2:0]        err
);

    localparam int N      = 8 + DATA_W + KEY_W;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]  LAST_RX_BIT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  LAST_TX_BIT = CNT_W'(DATA_W - 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST   = WCNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_LAUNCH,
        S_WAIT,
        S_MARK,
        S_TX,
        S_DRAIN
    } state_t;

    state_t              state;
    logic [N-1:0]        frame_sr;
    logic [DATA_W-1:0]   result_sr;
    logic [CNT_W-1:0]    bit_cnt;
    logic [WCNT_W-1:0]   wait_cnt;
    logic                miso_oe;
    logic                miso_dat;

    logic [N-1:0]        frame_nxt;
    logic                cmd_bad;
    logic                abort;

    // Frame is shifted in MSB first, so after the last bit the layout is {cmd, data, key}.
    assign frame_nxt = {frame_sr[N-2:0], MOSI};
    // Reserved command bits [6:0] as they will sit once the current bit is shifted in.
    assign cmd_bad   = (frame_nxt[N-2 -: 7] != 7'd0);
    // CS deasserted while a transaction is in flight; outranks core_done and timeout.
    assign abort     = CS && (state != S_IDLE) && (state != S_DRAIN);

    // The core sees the capture register directly: it only moves again once the next frame starts.
    assign core_decrypt = frame_sr[N-1];
    assign core_data    = frame_sr[N-9 -: DATA_W];
    assign core_key     = frame_sr[KEY_W-1:0];

    assign MISO = miso_oe ? miso_dat : 1'bz;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            frame_sr   <= '0;
            result_sr  <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            miso_oe    <= 1'b0;
            miso_dat   <= 1'b0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            err        <= 3'b000;
        end else if (abort) begin
            state      <= S_IDLE;
            err[0]     <= 1'b1;
            busy       <= 1'b0;
            miso_oe    <= 1'b0;
            miso_dat   <= 1'b0;
            core_start <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!CS) begin
                        frame_sr <= frame_nxt;
                        bit_cnt  <= CNT_W'(1);
                        err      <= 3'b000;
                        busy     <= 1'b1;
                        state    <= S_RX;
                    end
                end
                S_RX: begin
                    frame_sr <= frame_nxt;
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_RX_BIT) begin
                        if (cmd_bad) begin
                            err[2] <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_DRAIN;
                        end else begin
                            core_start <= 1'b1;
                            miso_oe    <= 1'b1;
                            miso_dat   <= 1'b0;
                            state      <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    core_start <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // core_done is checked first so a result on the terminal cycle is kept.
                    if (core_done) begin
                        result_sr <= core_result;
                        miso_dat  <= 1'b1;
                        state     <= S_MARK;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err[1]  <= 1'b1;
                        busy    <= 1'b0;
                        miso_oe <= 1'b0;
                        state   <= S_DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_MARK: begin
                    miso_dat  <= result_sr[DATA_W-1];
                    result_sr <= {result_sr[DATA_W-2:0], 1'b0};
                    bit_cnt   <= '0;
                    state     <= S_TX;
                end
                S_TX: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_TX_BIT) begin
                        busy     <= 1'b0;
                        miso_oe  <= 1'b0;
                        miso_dat <= 1'b0;
                        state    <= S_DRAIN;
                    end else begin
                        miso_dat  <= result_sr[DATA_W-1];
                        result_sr <= {result_sr[DATA_W-2:0], 1'b0};
                    end
                end
                S_DRAIN: begin
                    if (CS) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
